temp_sampler: RTL and testbench
===============================

# temp_sampler

Sequencer for the FPGA on-die temperature sensor on the DE5 bridge board. It runs in the 50 MHz management domain. It drives the sensor's clear and enable controls and captures each finished 8-bit conversion. From those samples it produces a current value, a block average, a peak-hold value and an over-temperature alarm with hysteresis. Its outputs feed the seven-segment display driver and the SoC status registers.

## Interface
- `SAMPLE_PERIOD`, 50_000_000: idle cycles between the end of one conversion and the start of the next (≥2).
- `CLEAR_CYCLES`, 4: cycles `temp_clear` is held high before each conversion (≥1).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles in CONVERT waiting for `temp_valid`.
- `AVG_LOG2`, 3: the block average covers 2^AVG_LOG2 samples (0..6).
- `ALARM_HI`, 8'd213: alarm set threshold, raw code (85 °C = code − 128).
- `ALARM_LO`, 8'd203: alarm clear threshold. Must be < `ALARM_HI`.
- `clk_50mhz` in 1: sole clock.
- `rst_50mhz_n` in 1: reset, asynchronous, active-low.
- `temp_valid` in 1: sensor conversion-done. Asynchronous to `clk_50mhz`; a level that stays high until clear.
- `temp_val` in 8: sensor raw code. Stable while `temp_valid` is high.
- `peak_clear` in 1: one-cycle pulse that resets the peak-hold value.
- `temp_en` out 1: sensor enable.
- `temp_clear` out 1: sensor clear.
- `temp_cur` out 8: last captured code.
- `temp_cur_valid` out 1: one-cycle pulse when `temp_cur` updates.
- `temp_avg` out 8: last block average.
- `temp_avg_valid` out 1: one-cycle pulse when `temp_avg` updates.
- `temp_peak` out 8: maximum captured code since reset or the last `peak_clear`.
- `temp_alarm` out 1: over-temperature flag with hysteresis.
- `temp_timeout` out 1: the last conversion timed out.

## Operation
- `temp_valid` passes through a 2-flop synchronizer (`valid_s`). `temp_val` is sampled only when `valid_s` is high.
- FSM states are IDLE, CLEAR, CONVERT and CAPTURE.
  - **Reset** enters CLEAR directly, so the first conversion needs no period wait.
  - **IDLE:** counter runs 0..SAMPLE_PERIOD−1, then goes to CLEAR with the counter zeroed.
  - **CLEAR:** `temp_clear`=1 for exactly CLEAR_CYCLES cycles, then CONVERT.
  - **CONVERT:** `temp_en`=1.
    - If `valid_s` → CAPTURE.
    - Else, if the counter reaches TIMEOUT_CYCLES−1 → set `temp_timeout`, emit no sample, go to IDLE.
    - If `valid_s` is high on the expiry cycle, valid wins.
  - **CAPTURE:** one cycle, `temp_en`=0.
    - `temp_cur`←`temp_val`, pulse `temp_cur_valid`, clear `temp_timeout`.
    - Update peak, alarm and accumulator, then go to IDLE.
- Peak:
  - If `peak_clear` arrives in a cycle other than CAPTURE, `temp_peak`←0.
  - In CAPTURE, `temp_peak`←max(`temp_peak`, sample). A simultaneous `peak_clear` gives `temp_peak`←sample.
- Alarm, evaluated in CAPTURE only:
  - sample ≥ ALARM_HI → 1.
  - sample ≤ ALARM_LO → 0.
  - Otherwise hold.
- Average:
  - Accumulator width 8+AVG_LOG2, plus a sample counter of AVG_LOG2 bits.
  - On the 2^AVG_LOG2-th sample: `temp_avg`←(acc+sample)>>AVG_LOG2 (truncating). Pulse `temp_avg_valid` in the same cycle as `temp_cur_valid`, then zero acc and the counter.
  - With AVG_LOG2=0, `temp_avg` mirrors every sample.
- A timeout does not disturb acc, the sample counter, peak or alarm.

## Timing
- All outputs are registered and are 0 in reset.
- `temp_en`/`temp_clear` are decoded from the registered state and must not glitch.
- `temp_clear` rises on the first cycle after reset release.
- `temp_clear` and `temp_en` are never high together.
- `temp_valid` rise to `temp_cur_valid` is 3 cycles: 2 synchronizer cycles plus the CAPTURE register.
- `temp_en` falls in the cycle `temp_cur_valid` is high.
- Sample spacing is SAMPLE_PERIOD + CLEAR_CYCLES + conversion time + 1.
- Asserting reset mid-conversion drops `temp_en` immediately and loses the partial average.

## Structure
- Package `temp_pkg` holds:
  - the state enum;
  - the `TEMP_OFFSET`=128 code-to-°C constant;
  - default thresholds.
- One sub-module, `sync2`: the generic two-flop synchronizer, reused by other cross-domain status bits.

## Test plan
Parameters for these tests: SAMPLE_PERIOD=10, CLEAR_CYCLES=4, TIMEOUT_CYCLES=50, AVG_LOG2=2.
1. **Reset release** → `temp_clear` high for cycles 1–4, `temp_en` high from cycle 5. `temp_valid` with `temp_val`=150 → `temp_cur`=150 and `temp_cur_valid` 3 cycles later; `temp_en` falls the same cycle.
2. **Four samples** 100, 101, 102, 104 → `temp_avg`=101 (407>>2) with `temp_avg_valid` on the 4th sample only. Spacing between `temp_clear` rises is 10+4+conv+1.
3. **Alarm hysteresis** with samples 210, 213, 208, 203, 204 → `temp_alarm` 0, 1, 1, 0, 0.
4. **Peak hold** with samples 120, 180, 150 → `temp_peak`=180. `peak_clear` in IDLE → 0. Next sample 140 → 140. `peak_clear` coincident with CAPTURE of 90 → 90.
5. **Timeout**: `temp_valid` never rises → `temp_timeout`=1 after 50 CONVERT cycles, `temp_en` low, no `temp_cur_valid`, next CLEAR after 10 cycles. A subsequent good sample clears `temp_timeout`.
6. **Reset mid-CONVERT** → `temp_en` low asynchronously, all outputs 0. On release, a new CLEAR phase starts.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types and constants for the on-die temperature sensor sequencer.
package temp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CONVERT,
    ST_CAPTURE
  } state_t;

  // Raw sensor code minus this offset gives degrees Celsius.
  localparam int unsigned TEMP_OFFSET = 128;

  localparam logic [7:0] ALARM_HI_DEF = 8'd213;
  localparam logic [7:0] ALARM_LO_DEF = 8'd203;

  function automatic logic signed [8:0] code_to_celsius(input logic [7:0] code);
    return $signed({1'b0, code}) - $signed(9'(TEMP_OFFSET));
  endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// Control/data link between the sequencer (master) and the temperature sensor (slave).
interface temp_sampler_if;
  logic       temp_valid;
  logic [7:0] temp_val;
  logic       temp_en;
  logic       temp_clear;

  modport master (input temp_valid, input temp_val, output temp_en, output temp_clear);
  modport slave  (output temp_valid, output temp_val, input temp_en, input temp_clear);
endinterface

// File: rtl/temp_sampler_sync2.sv
// Generic two-flop synchronizer for slow cross-domain level signals.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/temp_sampler.sv
// Sequences the on-die temperature sensor and derives current, average,
// peak-hold and hysteresis-alarm values from the captured conversions.
module temp_sampler
  import temp_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD  = 50_000_000,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned AVG_LOG2       = 3,
  parameter logic [7:0]  ALARM_HI       = ALARM_HI_DEF,
  parameter logic [7:0]  ALARM_LO       = ALARM_LO_DEF
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_50mhz_n,
  temp_sampler_if.master        sensor,
  input  logic                  peak_clear,
  output logic [7:0]            temp_cur,
  output logic                  temp_cur_valid,
  output logic [7:0]            temp_avg,
  output logic                  temp_avg_valid,
  output logic [7:0]            temp_peak,
  output logic                  temp_alarm,
  output logic                  temp_timeout
);
  localparam int unsigned CNT_MAX_A = (SAMPLE_PERIOD > TIMEOUT_CYCLES) ? SAMPLE_PERIOD : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CLEAR_CYCLES) ? CNT_MAX_A : CLEAR_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned ACC_W     = 8 + AVG_LOG2;
  localparam int unsigned ACNT_W    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned AVG_LAST  = (1 << AVG_LOG2) - 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [ACNT_W-1:0] acnt;
  logic              valid_s;

  sync2 #(.WIDTH(1)) u_sync2 (
    .clk   (clk_50mhz),
    .rst_n (rst_50mhz_n),
    .d     (sensor.temp_valid),
    .q     (valid_s)
  );

  assign sum = acc + ACC_W'(sensor.temp_val);

  // Outputs are written on the same edge as the state they belong to, so the
  // capture results appear in the CAPTURE cycle and en/clear never glitch.
  // CLEAR counts from 1 when entered from IDLE; the reset entry spends its
  // first cycle bringing temp_clear up, giving CLEAR_CYCLES high cycles either way.
  always_ff @(posedge clk_50mhz or negedge rst_50mhz_n) begin
    if (!rst_50mhz_n) begin
      state             <= ST_CLEAR;
      cnt               <= '0;
      sensor.temp_en    <= 1'b0;
      sensor.temp_clear <= 1'b0;
      temp_cur          <= '0;
      temp_cur_valid    <= 1'b0;
      temp_avg          <= '0;
      temp_avg_valid    <= 1'b0;
      temp_peak         <= '0;
      temp_alarm        <= 1'b0;
      temp_timeout      <= 1'b0;
      acc               <= '0;
      acnt              <= '0;
    end else begin
      temp_cur_valid <= 1'b0;
      temp_avg_valid <= 1'b0;
      if (peak_clear) begin
        temp_peak <= (state == ST_CAPTURE) ? temp_cur : '0;
      end

      case (state)
        ST_IDLE: begin
          if (cnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
            state             <= ST_CLEAR;
            cnt               <= CNT_W'(1);
            sensor.temp_clear <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CLEAR: begin
          if (cnt == CNT_W'(CLEAR_CYCLES)) begin
            state             <= ST_CONVERT;
            cnt               <= '0;
            sensor.temp_clear <= 1'b0;
            sensor.temp_en    <= 1'b1;
          end else begin
            cnt               <= cnt + 1'b1;
            sensor.temp_clear <= 1'b1;
          end
        end

        ST_CONVERT: begin
          if (valid_s) begin
            state          <= ST_CAPTURE;
            sensor.temp_en <= 1'b0;
            temp_cur       <= sensor.temp_val;
            temp_cur_valid <= 1'b1;
            temp_timeout   <= 1'b0;
            if (peak_clear || (sensor.temp_val > temp_peak)) begin
              temp_peak <= sensor.temp_val;
            end
            if (sensor.temp_val >= ALARM_HI) begin
              temp_alarm <= 1'b1;
            end else if (sensor.temp_val <= ALARM_LO) begin
              temp_alarm <= 1'b0;
            end
            if (acnt == ACNT_W'(AVG_LAST)) begin
              temp_avg       <= 8'(sum >> AVG_LOG2);
              temp_avg_valid <= 1'b1;
              acc            <= '0;
              acnt           <= '0;
            end else begin
              acc  <= sum;
              acnt <= acnt + 1'b1;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            sensor.temp_en <= 1'b0;
            temp_timeout   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_CAPTURE: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end

        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_temp_sampler.sv
// Directed-vector bench for temp_sampler with a hand-driven sensor model.
module tb_temp_sampler;
  localparam int unsigned SP = 10;
  localparam int unsigned CC = 4;
  localparam int unsigned TO = 50;
  localparam int unsigned AL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       peak_clear = 1'b0;
  logic [7:0] temp_cur, temp_avg, temp_peak;
  logic       temp_cur_valid, temp_avg_valid, temp_alarm, temp_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clr_rise[$];
  logic clr_prev = 1'b0;

  temp_sampler_if sif ();

  temp_sampler #(
    .SAMPLE_PERIOD  (SP),
    .CLEAR_CYCLES   (CC),
    .TIMEOUT_CYCLES (TO),
    .AVG_LOG2       (AL),
    .ALARM_HI       (8'd213),
    .ALARM_LO       (8'd203)
  ) dut (
    .clk_50mhz      (clk),
    .rst_50mhz_n    (rst_n),
    .sensor         (sif),
    .peak_clear     (peak_clear),
    .temp_cur       (temp_cur),
    .temp_cur_valid (temp_cur_valid),
    .temp_avg       (temp_avg),
    .temp_avg_valid (temp_avg_valid),
    .temp_peak      (temp_peak),
    .temp_alarm     (temp_alarm),
    .temp_timeout   (temp_timeout)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sif.temp_clear && !clr_prev) clr_rise.push_back(cyc);
    clr_prev = sif.temp_clear;
    if (rst_n) begin
      total++;
      if (sif.temp_en && sif.temp_clear) begin
        bad++;
        $display("FAIL en_clear_overlap: en=%b clear=%b required not both 1 at cycle %0d",
                 sif.temp_en, sif.temp_clear, cyc);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    sif.temp_valid = 1'b0;
    sif.temp_val = 8'd0;
    peak_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_clear_drop_valid();
    int n = 0;
    while (!sif.temp_clear && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!sif.temp_clear) begin
      bad++;
      $display("FAIL wait_clear: clear=%b required 1 within 100 cycles", sif.temp_clear);
    end
    sif.temp_valid = 1'b0;
  endtask

  // Sensor model: wait for enable, finish after dly cycles, report capture observations.
  task automatic do_sample(input logic [7:0] v, input int dly, output int lat,
                           output logic en_at, output logic avgv, output logic [7:0] avg_at);
    int n = 0;
    lat = -1; en_at = 1'b1; avgv = 1'b0; avg_at = 8'd0;
    if (sif.temp_valid) wait_clear_drop_valid();
    while (!sif.temp_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!sif.temp_en) begin
      bad++;
      $display("FAIL wait_en: en=%b required 1 within 200 cycles", sif.temp_en);
      return;
    end
    repeat (dly) @(negedge clk);
    sif.temp_val = v;
    sif.temp_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (temp_cur_valid) begin
        lat = k; en_at = sif.temp_en; avgv = temp_avg_valid; avg_at = temp_avg;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat; logic en_at, avgv; logic [7:0] avg_at;
    logic [1:0] exp_ce;
    rst_n = 1'b0; sif.temp_valid = 1'b0; sif.temp_val = 8'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({sif.temp_en, sif.temp_clear, temp_cur, temp_cur_valid, temp_avg, temp_avg_valid,
         temp_peak, temp_alarm, temp_timeout} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b clr=%b cur=%0d cv=%b avg=%0d av=%b peak=%0d al=%b to=%b required all 0",
               sif.temp_en, sif.temp_clear, temp_cur, temp_cur_valid, temp_avg, temp_avg_valid,
               temp_peak, temp_alarm, temp_timeout);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp_ce = {(i <= 4) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0};
      total++;
      if ({sif.temp_clear, sif.temp_en} !== exp_ce) begin
        bad++;
        $display("FAIL release_cycle%0d: clear,en=%b required %b", i, {sif.temp_clear, sif.temp_en}, exp_ce);
      end
    end
    do_sample(8'd150, 0, lat, en_at, avgv, avg_at);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL first_latency: got %0d required 3", lat); end
    total++;
    if (en_at !== 1'b0) begin bad++; $display("FAIL en_fall: en=%b required 0", en_at); end
    total++;
    if (temp_cur !== 8'd150) begin bad++; $display("FAIL first_cur: got %0d required 150", temp_cur); end
    total++;
    if (temp_peak !== 8'd150) begin bad++; $display("FAIL first_peak: got %0d required 150", temp_peak); end
    total++;
    if (avgv !== 1'b0) begin bad++; $display("FAIL first_avg_valid: got %b required 0", avgv); end
  endtask

  task automatic test_average();
    logic [7:0] vals [4] = '{8'd100, 8'd101, 8'd102, 8'd104};
    logic       expv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat; logic en_at, avgv; logic [7:0] avg_at;
    int n = 0;
    apply_reset();
    clr_rise.delete();
    for (int i = 0; i < 4; i++) begin
      do_sample(vals[i], 2, lat, en_at, avgv, avg_at);
      total++;
      if (avgv !== expv[i]) begin
        bad++; $display("FAIL avg_valid_s%0d: got %b required %b", i, avgv, expv[i]);
      end
    end
    total++;
    if (avg_at !== 8'd101) begin bad++; $display("FAIL avg_value: got %0d required 101", avg_at); end
    while (clr_rise.size() < 5 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (clr_rise.size() < 5) begin
      bad++; $display("FAIL clear_rises: got %0d required 5", clr_rise.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        total++;
        if (clr_rise[i] - clr_rise[i-1] !== 20) begin
          bad++; $display("FAIL spacing%0d: got %0d required 20", i, clr_rise[i] - clr_rise[i-1]);
        end
      end
    end
  endtask

  task automatic test_alarm();
    logic [7:0] vals [5] = '{8'd210, 8'd213, 8'd208, 8'd203, 8'd204};
    logic       expa [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat; logic en_at, avgv; logic [7:0] avg_at;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_sample(vals[i], 1, lat, en_at, avgv, avg_at);
      total++;
      if (temp_alarm !== expa[i]) begin
        bad++; $display("FAIL alarm_s%0d(%0d): got %b required %b", i, vals[i], temp_alarm, expa[i]);
      end
    end
  endtask

  task automatic test_peak();
    logic [7:0] vals [3] = '{8'd120, 8'd180, 8'd150};
    int lat; logic en_at, avgv; logic [7:0] avg_at;
    apply_reset();
    for (int i = 0; i < 3; i++) do_sample(vals[i], 0, lat, en_at, avgv, avg_at);
    total++;
    if (temp_peak !== 8'd180) begin bad++; $display("FAIL peak_hold: got %0d required 180", temp_peak); end
    repeat (2) @(negedge clk);
    peak_clear = 1'b1;
    @(negedge clk);
    peak_clear = 1'b0;
    total++;
    if (temp_peak !== 8'd0) begin bad++; $display("FAIL peak_clear_idle: got %0d required 0", temp_peak); end
    do_sample(8'd140, 0, lat, en_at, avgv, avg_at);
    total++;
    if (temp_peak !== 8'd140) begin bad++; $display("FAIL peak_after_clear: got %0d required 140", temp_peak); end
    do_sample(8'd90, 0, lat, en_at, avgv, avg_at);
    peak_clear = 1'b1;
    @(negedge clk);
    peak_clear = 1'b0;
    total++;
    if (temp_peak !== 8'd90) begin bad++; $display("FAIL peak_clear_capture: got %0d required 90", temp_peak); end
  endtask

  task automatic test_timeout();
    int lat; logic en_at, avgv; logic [7:0] avg_at;
    int n_en = 0;
    int k = 0;
    int n = 0;
    logic saw_cv = 1'b0;
    apply_reset();
    do_sample(8'd220, 0, lat, en_at, avgv, avg_at);
    wait_clear_drop_valid();
    while (!sif.temp_en && n < 200) begin @(negedge clk); n++; end
    while (sif.temp_en && n_en < 200) begin
      if (temp_cur_valid) saw_cv = 1'b1;
      @(negedge clk);
      n_en++;
    end
    total++;
    if (n_en !== 50) begin bad++; $display("FAIL timeout_en_cycles: got %0d required 50", n_en); end
    total++;
    if (saw_cv !== 1'b0 || temp_cur_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_no_sample: cur_valid seen=%b required 0", saw_cv | temp_cur_valid);
    end
    total++;
    if (temp_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %b required 1", temp_timeout); end
    total++;
    if ({temp_alarm, temp_peak, temp_cur} !== {1'b1, 8'd220, 8'd220}) begin
      bad++; $display("FAIL timeout_keeps_state: alarm=%b peak=%0d cur=%0d required 1/220/220",
                      temp_alarm, temp_peak, temp_cur);
    end
    while (!sif.temp_clear && k < 50) begin @(negedge clk); k++; end
    total++;
    if (k !== 10) begin bad++; $display("FAIL timeout_idle_gap: got %0d required 10", k); end
    do_sample(8'd77, 1, lat, en_at, avgv, avg_at);
    total++;
    if ({temp_timeout, temp_cur, temp_alarm, temp_peak} !== {1'b0, 8'd77, 1'b0, 8'd220}) begin
      bad++; $display("FAIL timeout_recover: to=%b cur=%0d alarm=%b peak=%0d required 0/77/0/220",
                      temp_timeout, temp_cur, temp_alarm, temp_peak);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic en_at, avgv; logic [7:0] avg_at;
    int n = 0;
    apply_reset();
    do_sample(8'd200, 0, lat, en_at, avgv, avg_at);
    do_sample(8'd200, 0, lat, en_at, avgv, avg_at);
    wait_clear_drop_valid();
    while (!sif.temp_en && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({sif.temp_en, sif.temp_clear, temp_cur, temp_cur_valid, temp_avg, temp_avg_valid,
         temp_peak, temp_alarm, temp_timeout} !== 30'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: en=%b clr=%b cur=%0d peak=%0d al=%b required all 0",
               sif.temp_en, sif.temp_clear, temp_cur, temp_peak, temp_alarm);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({sif.temp_clear, sif.temp_en} !== 2'b10) begin
      bad++; $display("FAIL mid_reset_restart: clear,en=%b required 10", {sif.temp_clear, sif.temp_en});
    end
    for (int i = 0; i < 4; i++) begin
      do_sample(8'd8, 0, lat, en_at, avgv, avg_at);
      total++;
      if (avgv !== ((i == 3) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL mid_reset_avg_valid_s%0d: got %b required %b", i, avgv, (i == 3));
      end
    end
    total++;
    if (avg_at !== 8'd8) begin bad++; $display("FAIL mid_reset_avg: got %0d required 8", avg_at); end
  endtask

  initial begin
    sif.temp_valid = 1'b0;
    sif.temp_val = 8'd0;
    test_reset();
    test_average();
    test_alarm();
    test_peak();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
